// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the anti-theft alarm controller:
// state codes, parameter-select encoding, time type and default intervals.
package alarm_controller_pkg;

    typedef logic [3:0] time_t;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_SOUND      = 3'd2,
        ST_HOLD       = 3'd3,
        ST_DISARMED   = 3'd4,
        ST_WAIT_OPEN  = 3'd5,
        ST_WAIT_CLOSE = 3'd6,
        ST_ARM_DELAY  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARM       = 2'd0,
        SEL_DRIVER    = 2'd1,
        SEL_PASSENGER = 2'd2,
        SEL_ALARM     = 2'd3
    } param_sel_t;

    localparam time_t T_ARM_DEFAULT       = 4'd6;
    localparam time_t T_DRIVER_DEFAULT    = 4'd8;
    localparam time_t T_PASSENGER_DEFAULT = 4'd15;
    localparam time_t T_ALARM_DEFAULT     = 4'd10;

    // A zero-length countdown would never start, so it is stored as one second.
    function automatic time_t clamp_time(input time_t v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/alarm_controller_time_parameters.sv
// User-programmable interval registers with zero-clamped writes and a
// read mux selecting one of the four intervals.
module time_parameters
    import alarm_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_write,
    input  logic [1:0] i_write_sel,
    input  logic [3:0] i_write_value,
    input  logic [1:0] i_read_sel,
    output logic [3:0] o_read_value
);

    time_t r_params [4];

    // NOTE: this small register file is reset because the defaults are part of
    // the reset state; a large RAM would normally be left unreset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_params[SEL_ARM]       <= T_ARM_DEFAULT;
            r_params[SEL_DRIVER]    <= T_DRIVER_DEFAULT;
            r_params[SEL_PASSENGER] <= T_PASSENGER_DEFAULT;
            r_params[SEL_ALARM]     <= T_ALARM_DEFAULT;
        end else if (i_write) begin
            r_params[i_write_sel] <= clamp_time(i_write_value);
        end
    end

    assign o_read_value = r_params[i_read_sel];

endmodule

// File: rtl/alarm_controller.sv
// Central anti-theft state machine: arming, intrusion detection, siren
// control, countdown-timer commands and the fuel-pump interlock.
module alarm_controller
    import alarm_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_ignition,
    input  logic       i_door_driver,
    input  logic       i_door_pass,
    input  logic       i_hidden_sw,
    input  logic       i_brake,
    input  logic       i_reprogram,
    input  logic [1:0] i_param_sel,
    input  logic [3:0] i_time_value,
    input  logic       i_expired,
    input  logic       i_half_hz_enable,
    output logic       o_start_timer,
    output logic [3:0] o_value,
    output logic       o_siren,
    output logic       o_status,
    output logic       o_fuel_pump,
    output logic [2:0] o_state_display
);

    state_t     r_state;
    state_t     w_next_state;
    param_sel_t r_interval;
    param_sel_t w_next_interval;
    logic       w_start;
    logic       w_expired_ok;
    logic       w_any_door;
    logic [3:0] w_param_value;
    logic       r_start_timer;
    logic       r_start_d;
    logic [3:0] r_value;
    logic       r_siren;
    logic       r_status;
    logic       r_fuel_pump;

    time_parameters u_time_parameters (
        .clock         (clock),
        .reset         (reset),
        .i_write       (i_reprogram),
        .i_write_sel   (i_param_sel),
        .i_write_value (i_time_value),
        .i_read_sel    (w_next_interval),
        .o_read_value  (w_param_value)
    );

    // The timer still shows its previous count during the load pulse and the
    // cycle after it, so expiry is not trusted until then.
    assign w_expired_ok = i_expired & ~r_start_timer & ~r_start_d;
    assign w_any_door   = i_door_driver | i_door_pass;

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_interval = r_interval;
        w_start         = 1'b0;
        if (i_ignition) begin
            w_next_state = ST_DISARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (i_door_driver) begin
                        w_next_state    = ST_TRIGGERED;
                        w_next_interval = SEL_DRIVER;
                        w_start         = 1'b1;
                    end else if (i_door_pass) begin
                        w_next_state    = ST_TRIGGERED;
                        w_next_interval = SEL_PASSENGER;
                        w_start         = 1'b1;
                    end
                end
                ST_TRIGGERED: if (w_expired_ok) w_next_state = ST_SOUND;
                ST_SOUND: begin
                    if (!w_any_door) begin
                        w_next_state    = ST_HOLD;
                        w_next_interval = SEL_ALARM;
                        w_start         = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_any_door)        w_next_state = ST_SOUND;
                    else if (w_expired_ok) w_next_state = ST_ARMED;
                end
                ST_DISARMED:  w_next_state = ST_WAIT_OPEN;
                ST_WAIT_OPEN: if (i_door_driver) w_next_state = ST_WAIT_CLOSE;
                ST_WAIT_CLOSE: begin
                    if (!w_any_door) begin
                        w_next_state    = ST_ARM_DELAY;
                        w_next_interval = SEL_ARM;
                        w_start         = 1'b1;
                    end
                end
                ST_ARM_DELAY: begin
                    if (w_any_door)        w_next_state = ST_WAIT_CLOSE;
                    else if (w_expired_ok) w_next_state = ST_ARMED;
                end
                default: w_next_state = ST_ARMED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ARMED;
            r_interval    <= SEL_ARM;
            r_start_timer <= 1'b0;
            r_start_d     <= 1'b0;
            r_value       <= T_ARM_DEFAULT;
            r_siren       <= 1'b0;
            r_status      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_start_timer <= w_start;
            r_start_d     <= r_start_timer;
            r_siren       <= (w_next_state == ST_SOUND) || (w_next_state == ST_HOLD);
            if (w_start) begin
                r_interval <= w_next_interval;
                r_value    <= w_param_value;
            end
            case (w_next_state)
                ST_ARMED:                          r_status <= i_half_hz_enable;
                ST_TRIGGERED, ST_SOUND, ST_HOLD:   r_status <= 1'b1;
                default:                           r_status <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                         r_fuel_pump <= 1'b0;
        else if (!i_ignition)                              r_fuel_pump <= 1'b0;
        else if (i_hidden_sw && i_brake)                   r_fuel_pump <= 1'b1;
    end

    assign o_start_timer   = r_start_timer;
    assign o_value         = r_value;
    assign o_siren         = r_siren;
    assign o_status        = r_status;
    assign o_fuel_pump     = r_fuel_pump;
    assign o_state_display = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: a behavioural model predicts each
// cycle's outputs, a monitor compares them one edge later.
module tb_alarm_controller;

    localparam int ARMED = 0, TRIG = 1, SOUND = 2, HOLD = 3;
    localparam int DIS = 4, WOPEN = 5, WCLOSE = 6, ADELAY = 7;

    typedef struct {
        bit       ign, dd, dp, hs, br, rp, exp, hz;
        int       ps, tv;
    } stim_t;

    typedef struct {
        int state;
        bit start;
        int value;
        bit hz;
        bit fuel;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ignition = 0, door_driver = 0, door_pass = 0, hidden_sw = 0, brake = 0;
    logic       reprogram = 0, expired = 0, half_hz_enable = 0;
    logic [1:0] param_sel = 0;
    logic [3:0] time_value = 0;
    logic       start_timer, siren, status, fuel_pump;
    logic [3:0] value;
    logic [2:0] state_display;

    int n_checks = 0;
    int n_errors = 0;

    stim_t s;
    exp_t  exp_q[$];

    // Reference model: intervals as an array, guard as "cycles since load".
    int m_state, m_value, m_age;
    int m_params[4];
    bit m_fuel;

    alarm_controller dut (
        .clock            (clock),
        .reset            (reset),
        .i_ignition       (ignition),
        .i_door_driver    (door_driver),
        .i_door_pass      (door_pass),
        .i_hidden_sw      (hidden_sw),
        .i_brake          (brake),
        .i_reprogram      (reprogram),
        .i_param_sel      (param_sel),
        .i_time_value     (time_value),
        .i_expired        (expired),
        .i_half_hz_enable (half_hz_enable),
        .o_start_timer    (start_timer),
        .o_value          (value),
        .o_siren          (siren),
        .o_status         (status),
        .o_fuel_pump      (fuel_pump),
        .o_state_display  (state_display)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ARMED;
        m_value = 6;
        m_age   = 3;
        m_fuel  = 0;
        m_params[0] = 6; m_params[1] = 8; m_params[2] = 15; m_params[3] = 10;
    endtask

    // Apply one cycle of stimulus, predict the post-edge outputs, advance.
    task automatic step();
        exp_t e;
        int   nxt, sel;
        bit   st, ok, anyd;
        ignition = s.ign; door_driver = s.dd; door_pass = s.dp;
        hidden_sw = s.hs; brake = s.br; reprogram = s.rp;
        param_sel = 2'(s.ps); time_value = 4'(s.tv);
        expired = s.exp; half_hz_enable = s.hz;

        ok   = s.exp && (m_age >= 2);
        anyd = s.dd || s.dp;
        nxt  = m_state; st = 0; sel = 0;
        if (s.ign) nxt = DIS;
        else case (m_state)
            ARMED:  if (s.dd) begin nxt = TRIG; st = 1; sel = 1; end
                    else if (s.dp) begin nxt = TRIG; st = 1; sel = 2; end
            TRIG:   if (ok) nxt = SOUND;
            SOUND:  if (!anyd) begin nxt = HOLD; st = 1; sel = 3; end
            HOLD:   if (anyd) nxt = SOUND; else if (ok) nxt = ARMED;
            DIS:    nxt = WOPEN;
            WOPEN:  if (s.dd) nxt = WCLOSE;
            WCLOSE: if (!anyd) begin nxt = ADELAY; st = 1; sel = 0; end
            ADELAY: if (anyd) nxt = WCLOSE; else if (ok) nxt = ARMED;
            default: nxt = ARMED;
        endcase
        if (st) m_value = m_params[sel];
        if (s.rp) m_params[s.ps] = (s.tv == 0) ? 1 : s.tv;
        if (!s.ign) m_fuel = 0;
        else if (s.hs && s.br) m_fuel = 1;
        m_age   = st ? 0 : ((m_age < 3) ? m_age + 1 : 3);
        m_state = nxt;

        e.state = m_state; e.start = st; e.value = m_value; e.hz = s.hz; e.fuel = m_fuel;
        exp_q.push_back(e);
        @(posedge clock);
        #3;
    endtask

    // Monitor: compares the outputs of each edge against the model.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_state", int'(state_display), e.state);
            check("sb_start", int'(start_timer), int'(e.start));
            if (e.start) check("sb_value", int'(value), e.value);
            check("sb_siren", int'(siren), int'(e.state == SOUND || e.state == HOLD));
            check("sb_status", int'(status),
                  (e.state == ARMED) ? int'(e.hz) : int'(e.state >= TRIG && e.state <= HOLD));
            check("sb_fuel", int'(fuel_pump), int'(e.fuel));
        end
    end

    task automatic expire();
        s.exp = 1;
        repeat (3) step();
        s.exp = 0;
    endtask

    task automatic rearm();
        s.ign = 1; step();
        s.ign = 0; step();
        s.dd = 1; step();
        s.dd = 0; step();
        expire();
        check("rearm_state", int'(state_display), ARMED);
    endtask

    initial begin
        s = '{default: 0};
        model_reset();
        #12;
        check("rst_state", int'(state_display), 0);
        check("rst_start", int'(start_timer), 0);
        check("rst_siren", int'(siren), 0);
        check("rst_status", int'(status), 0);
        check("rst_fuel", int'(fuel_pump), 0);
        reset = 1'b0;
        @(posedge clock); #3;

        // Driver intrusion, expiry guard, siren.
        s.dd = 1; step();
        check("drv_start", int'(start_timer), 1);
        check("drv_value", int'(value), 8);
        check("drv_state", int'(state_display), TRIG);
        s.exp = 1; step();
        check("guard_pulse", int'(state_display), TRIG);
        step();
        check("guard_after", int'(state_display), TRIG);
        step();
        check("sound_state", int'(state_display), SOUND);
        check("sound_siren", int'(siren), 1);
        s.exp = 0;

        // Doors close -> HOLD, reopen -> SOUND, close and expire -> ARMED.
        s.dd = 0; step();
        check("hold_value", int'(value), 10);
        check("hold_state", int'(state_display), HOLD);
        s.dp = 1; step();
        check("reopen_state", int'(state_display), SOUND);
        s.dp = 0; step();
        expire();
        check("rearmed_state", int'(state_display), ARMED);
        check("rearmed_siren", int'(siren), 0);

        // Both doors together: driver delay wins; ignition in HOLD disarms.
        s.dd = 1; s.dp = 1; step();
        check("both_value", int'(value), 8);
        expire();
        s.dd = 0; s.dp = 0; step();
        s.ign = 1; step();
        check("ign_state", int'(state_display), DIS);
        check("ign_siren", int'(siren), 0);

        // Disarm sequence with a door reopening during the arm delay.
        s.ign = 0; step();
        s.dd = 1; step();
        s.dd = 0; step();
        check("armdly_value", int'(value), 6);
        check("armdly_state", int'(state_display), ADELAY);
        s.dp = 1; step();
        check("armdly_reopen", int'(state_display), WCLOSE);
        s.dp = 0; step();
        s.exp = 1; step(); step();
        s.hz = 1; step();
        check("armed_hz1", int'(status), 1);
        s.exp = 0; s.hz = 0; step();
        check("armed_hz0", int'(status), 0);

        // Zero write clamps to one.
        s.rp = 1; s.ps = 2; s.tv = 0; step();
        s.rp = 0; s.dp = 1; step();
        check("clamp_value", int'(value), 1);
        s.dp = 0;
        rearm();

        // Write to the driver interval in the same cycle as the load.
        s.rp = 1; s.ps = 1; s.tv = 3; s.dd = 1; step();
        check("same_cyc_old", int'(value), 8);
        s.rp = 0; s.dd = 0;
        rearm();
        s.dd = 1; step();
        check("new_drv_value", int'(value), 3);
        s.dd = 0;

        // Fuel-pump interlock.
        s.ign = 1; s.hs = 1; s.br = 1; step();
        check("fuel_set", int'(fuel_pump), 1);
        s.br = 0; step();
        check("fuel_hold", int'(fuel_pump), 1);
        s.ign = 0; step();
        check("fuel_clear", int'(fuel_pump), 0);
        s.hs = 0;

        // Reset in the middle of a countdown.
        rearm();
        s.dp = 1; step();
        s.dp = 0; step();
        reset = 1'b1;
        #1;
        check("midrst_state", int'(state_display), ARMED);
        check("midrst_siren", int'(siren), 0);
        check("midrst_start", int'(start_timer), 0);
        model_reset();
        exp_q.delete();
        #1 reset = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            s.ign = ($urandom_range(0, 99) < 4);
            s.dd  = ($urandom_range(0, 99) < 15);
            s.dp  = ($urandom_range(0, 99) < 15);
            s.hs  = ($urandom_range(0, 1) == 1);
            s.br  = ($urandom_range(0, 1) == 1);
            s.rp  = ($urandom_range(0, 99) < 8);
            s.ps  = int'($urandom_range(0, 3));
            s.tv  = int'($urandom_range(0, 15));
            s.exp = ($urandom_range(0, 99) < 35);
            s.hz  = ($urandom_range(0, 1) == 1);
            step();
        end

        s = '{default: 0};
        step();
        #5;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Central state machine of the anti-theft system. Sequences arming, intrusion detection and siren control from the ignition and door switches, and commands the countdown timer by issuing a one-cycle `start_timer` pulse with a 4-bit interval length. It consumes the timer's `expired` and `half_hz_enable` outputs, and includes the user-programmable time-parameter registers and the fuel-pump interlock.

## Interface
- `T_ARM_DEFAULT`, 6: arm delay, seconds, loaded at reset
- `T_DRIVER_DEFAULT`, 8: driver-door entry delay
- `T_PASSENGER_DEFAULT`, 15: passenger-door entry delay
- `T_ALARM_DEFAULT`, 10: siren hold time after doors close
- `clock`  in  1  system clock
- `reset`  in  1  reset, asynchronous, active-high
- `ignition`  in  1  ignition on, synchronous level
- `door_driver`, `door_pass`  in  1 each  door open (1 = open)
- `hidden_sw`, `brake`  in  1 each  fuel-pump enable inputs
- `reprogram`  in  1  one-cycle write strobe for a time parameter
- `param_sel`  in  2  0 arm, 1 driver, 2 passenger, 3 alarm
- `time_value`  in  4  new parameter value
- `expired`  in  1  timer count is zero
- `half_hz_enable`  in  1  0.5 Hz square wave from the timer
- `start_timer`  out  1  one-cycle load pulse to the timer
- `value`  out  4  interval length presented with `start_timer`
- `siren`, `status`, `fuel_pump`  out  1 each  actuators and LED
- `state_display`  out  3  current state code

## Operation
- States, 3-bit codes: ARMED 0, TRIGGERED 1, SOUND 2, HOLD 3, DISARMED 4, WAIT_OPEN 5, WAIT_CLOSE 6, ARM_DELAY 7.
- When `ignition`=1, every state goes to DISARMED. This has the highest priority.
- ARMED:
  - `door_driver` → TRIGGERED, start with driver delay.
  - Else `door_pass` → TRIGGERED, start with passenger delay.
  - Driver wins when both doors open together.
- TRIGGERED: `expired` → SOUND.
- SOUND: both doors closed → HOLD, start with alarm time.
- HOLD:
  - Any door open → SOUND.
  - Else `expired` → ARMED.
- DISARMED: `ignition`=0 → WAIT_OPEN.
- WAIT_OPEN: `door_driver` → WAIT_CLOSE.
- WAIT_CLOSE: both doors closed → ARM_DELAY, start with arm delay.
- ARM_DELAY:
  - Any door open → WAIT_CLOSE.
  - Else `expired` → ARMED.
- Outputs per state:
  - `siren` = 1 in SOUND and HOLD.
  - `status` = `half_hz_enable` in ARMED; 1 in TRIGGERED, SOUND and HOLD; 0 otherwise.
- Parameter registers:
  - A `reprogram` pulse writes `time_value` into register `param_sel`.
  - A written 0 is stored as 1.
  - The write does not change the state.
  - A countdown already running keeps its loaded length.
- `value` is the parameter register selected by the internal interval register. That register is updated in the same cycle as `start_timer`.
- Fuel pump:
  - `fuel_pump` sets when `ignition`, `hidden_sw` and `brake` are all 1 in the same cycle.
  - It clears when `ignition`=0.
  - It is independent of state.

## Timing
- `reset` is asynchronous. After reset:
  - State is ARMED; parameters are at their defaults; interval is arm.
  - `start_timer`=0, `siren`=0, `status`=0, `fuel_pump`=0, `state_display`=0.
- All outputs are registered. A change on an input causes the transition, and the new outputs, on the next clock edge.
- `start_timer` is high for exactly the first cycle of the new timed state.
- `value` is valid in the same cycle as `start_timer`.
- If `reprogram` targets the register being loaded in that same cycle, the old value is loaded.
- `expired` guard: `expired` is ignored while `start_timer`=1 and in the cycle immediately after. This covers the timer's load latency.
- Reset applied mid-countdown returns the block to ARMED with `siren`=0. No `start_timer` is issued.

## Structure
- Shared package holds:
  - The state enum and its codes.
  - The `param_sel` encoding.
  - The 4-bit time type.
  - The four default values.
- Sub-module `time_parameters` holds:
  - The four registers.
  - The write with zero-clamp.
  - The read mux that produces `value`.
- The state machine, output logic and fuel-pump flop stay in `alarm_controller`.

## Test plan
- Reset → `state_display`=0, all outputs 0. Open `door_driver` → one `start_timer` pulse with `value`=8, state 1. Bench raises `expired` → state 2, `siren`=1.
- In SOUND, close both doors → `start_timer` with `value`=10, state 3. Reopen `door_pass` → state 2. Close doors, then raise `expired` → state 0, `siren`=0.
- Open both doors together in ARMED → `value`=8 (driver priority). Ignition on during HOLD → state 4 and `siren`=0 the next cycle.
- Disarm sequence (ignition off, driver door open, close) → `start_timer` with `value`=6. Door reopens in ARM_DELAY → state 6. Close, then `expired` → state 0 with `status` following `half_hz_enable`.
- `reprogram` with `param_sel`=2 and `time_value`=0 → next passenger trigger loads `value`=1. A write in the same cycle as the start pulse loads the old value.
- With `ignition`=1, `hidden_sw`=1 and `brake`=1 → `fuel_pump`=1, and it stays 1 after `brake` drops. Drop `ignition` → `fuel_pump`=0.
